// File: rtl/uart_rx_if.sv
// uart_rx_if
// Bundles the serial-side inputs, the detector handshake and the byte-output
// valid/ready channel of the UART receive sequencer.
//   din         : serial line, synchronized to clk, idle high
//   start_valid : start-condition pulse from the start-edge detector
//   det_clear   : one-cycle clear back to the detector
//   rx_data     : received byte, LSB = first data bit on the line
//   rx_valid    : rx_data holds an unconsumed byte
//   rx_ready    : consumer accepts rx_data when rx_valid & rx_ready
//   frame_err   : one-cycle pulse, stop bit sampled low
//   overrun     : one-cycle pulse, good byte dropped because holding reg full
//   busy        : sequencer is inside a frame
// Modports: slave = the sequencer, master = whatever drives/consumes it.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 din;
  logic                 start_valid;
  logic                 det_clear;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport slave (
    input  din,
    input  start_valid,
    input  rx_ready,
    output det_clear,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport master (
    output din,
    output start_valid,
    output rx_ready,
    input  det_clear,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive-side sequencer of the UART receiver. Accepts a start-condition
// pulse, times the frame with a bit-period counter, samples din at mid-bit,
// assembles DATA_BITS data bits LSB-first, checks the stop bit and presents
// the byte through a one-entry valid/ready holding register. After every
// frame and every rejected start it pulses det_clear so the start-edge
// detector drops its stale history.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; forces IDLE and clears all registers
//   bus   : uart_rx_if.slave (din, start_valid, rx_ready in;
//           det_clear, rx_data, rx_valid, frame_err, overrun, busy out)
// Parameters:
//   CLKS_PER_BIT : clocks per serial bit, even and >= 4
//   DATA_BITS    : data bits per frame, 5..8
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W = $clog2(DATA_BITS + 1);

  // Start bit is judged half a bit in; every later sample is a full bit apart,
  // which keeps each sample centred in its bit cell.
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIDX_W-1:0]    bidx, bidx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_n;
  logic                 rx_valid_q, rx_valid_n;
  logic                 det_clear_q, det_clear_n;
  logic                 frame_err_q, frame_err_n;
  logic                 overrun_q, overrun_n;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bidx_n      = bidx;
    sh_n        = sh;
    rx_data_n   = rx_data_q;
    // A handshake empties the holding register unless a new byte loads
    // on the same edge (handled in STOP below).
    rx_valid_n  = rx_valid_q & ~bus.rx_ready;
    det_clear_n = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;

    case (state)
      IDLE: begin
        // While det_clear is out the detector is being flushed, so any
        // start pulse in that cycle is stale.
        if (bus.start_valid && !det_clear_q) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      START: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_HALF) begin
          if (bus.din) begin
            state_n     = IDLE;
            det_clear_n = 1'b1;
          end else begin
            state_n = DATA;
            cnt_n   = '0;
            bidx_n  = '0;
          end
        end
      end

      DATA: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          // Right shift: the first bit received ends up in the LSB.
          sh_n   = {bus.din, sh[DATA_BITS-1:1]};
          cnt_n  = '0;
          bidx_n = bidx + 1'b1;
          if (bidx == BIDX_LAST) begin
            state_n = STOP;
          end
        end
      end

      STOP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_n     = IDLE;
          cnt_n       = '0;
          det_clear_n = 1'b1;
          if (bus.din) begin
            if (!rx_valid_q || bus.rx_ready) begin
              rx_data_n  = sh;
              rx_valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end else begin
            frame_err_n = 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bidx        <= '0;
      sh          <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      det_clear_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bidx        <= bidx_n;
      sh          <= sh_n;
      rx_data_q   <= rx_data_n;
      rx_valid_q  <= rx_valid_n;
      det_clear_q <= det_clear_n;
      frame_err_q <= frame_err_n;
      overrun_q   <= overrun_n;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.det_clear = det_clear_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl. A frame-level reference model keeps
// the accepted start time of the current frame and derives every sample and
// output event from the frame timing arithmetic; all DUT outputs are compared
// against it after every clock, plus explicit expected values in the
// directed scenarios.
module tb_uart_rx_ctrl;
  localparam int C     = 16;
  localparam int D     = 8;
  localparam int H     = C / 2;
  localparam int OUT_T = H + (D + 1) * C;  // stop-sample cycle

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_rx_if #(.DATA_BITS(D)) bus ();

  uart_rx_ctrl #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state: what the outputs should be in the current cycle.
  bit         m_act   = 1'b0;
  int         m_t0    = 0;
  logic [7:0] m_bits  = '0;
  logic [7:0] m_data  = '0;
  bit         m_valid = 1'b0;
  bit         m_detc  = 1'b0;
  bit         m_fe    = 1'b0;
  bit         m_ov    = 1'b0;

  // Advance the model across the clock edge that ends cycle 'cyc'.
  task automatic model_step();
    int e;
    bit load, hs, ndc, nfe, nov;
    load = 0; ndc = 0; nfe = 0; nov = 0;
    if (reset) begin
      m_act = 0; m_valid = 0; m_data = '0; m_bits = '0;
      m_detc = 0; m_fe = 0; m_ov = 0;
    end else begin
      hs = m_valid && bus.rx_ready;
      if (!m_act) begin
        if (bus.start_valid && !m_detc) begin
          m_act = 1;
          m_t0  = cyc;
        end
      end else begin
        e = cyc - m_t0;
        if (e == H) begin
          if (bus.din) begin
            m_act = 0;
            ndc   = 1;
          end
        end else if (e > H && e < OUT_T && ((e - H) % C) == 0) begin
          m_bits[(e - H) / C - 1] = bus.din;
        end else if (e == OUT_T) begin
          m_act = 0;
          ndc   = 1;
          if (bus.din) begin
            if (!m_valid || bus.rx_ready) load = 1;
            else nov = 1;
          end else begin
            nfe = 1;
          end
        end
      end
      if (load) begin
        m_valid = 1;
        m_data  = m_bits;
      end else if (hs) begin
        m_valid = 0;
      end
      m_detc = ndc;
      m_fe   = nfe;
      m_ov   = nov;
    end
    cyc++;
  endtask

  task automatic compare_all();
    check_eq("busy", bus.busy, m_act);
    check_eq("det_clear", bus.det_clear, m_detc);
    check_eq("rx_valid", bus.rx_valid, m_valid);
    check_eq("rx_data", bus.rx_data, m_data);
    check_eq("frame_err", bus.frame_err, m_fe);
    check_eq("overrun", bus.overrun, m_ov);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rnd_ready);
    for (int i = 0; i < n; i++) begin
      bus.din         = 1'b1;
      bus.start_valid = 1'b0;
      bus.rx_ready    = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    bus.rx_ready = 1'b0;
  endtask

  // Drives one frame whose start_valid lands in the first driven cycle.
  // ready_mode: 0 = never ready, 1 = random, 2 = ready only in the
  // stop-sample cycle. abort_at >= 0 asserts reset in that frame cycle.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int ready_mode,
                            input bit extra_starts, input int abort_at);
    int slot;
    for (int i = 0; i <= OUT_T; i++) begin
      slot = i / C;
      if (slot == 0) bus.din = 1'b0;
      else if (slot <= D) bus.din = b[slot-1];
      else bus.din = stop;
      bus.start_valid = (i == 0) || (extra_starts && i > 0 && $urandom_range(0, 7) == 0);
      case (ready_mode)
        0:       bus.rx_ready = 1'b0;
        1:       bus.rx_ready = 1'($urandom_range(0, 1));
        default: bus.rx_ready = (i == OUT_T);
      endcase
      reset = (i == abort_at);
      tick();
      if (i == abort_at) break;
    end
    reset           = 1'b0;
    bus.din         = 1'b1;
    bus.start_valid = 1'b0;
    bus.rx_ready    = 1'b0;
  endtask

  task automatic false_start(input bit directed);
    for (int i = 0; i <= H; i++) begin
      bus.din         = (i < 4) ? 1'b0 : 1'b1;
      bus.start_valid = (i == 0);
      bus.rx_ready    = 1'b0;
      tick();
    end
    bus.start_valid = 1'b0;
    if (directed) begin
      check_eq("fs_det_clear", bus.det_clear, 1);
      check_eq("fs_busy", bus.busy, 0);
      check_eq("fs_rx_valid", bus.rx_valid, 0);
    end
  endtask

  task automatic drain();
    bus.din = 1'b1; bus.start_valid = 1'b0; bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    idle(2, 0);
  endtask

  initial begin
    int act, gap;
    bus.din = 1'b1; bus.start_valid = 1'b0; bus.rx_ready = 1'b0;

    // Reset
    reset = 1'b1;
    idle(3, 0);
    check_eq("rst_rx_data", bus.rx_data, 0);
    check_eq("rst_rx_valid", bus.rx_valid, 0);
    check_eq("rst_det_clear", bus.det_clear, 0);
    check_eq("rst_busy", bus.busy, 0);
    reset = 1'b0;
    idle(4, 0);

    // Good frame 0xA5, consumer not ready
    send_frame(8'hA5, 1'b1, 0, 1'b0, -1);
    check_eq("good_rx_data", bus.rx_data, 32'hA5);
    check_eq("good_rx_valid", bus.rx_valid, 1);
    check_eq("good_det_clear", bus.det_clear, 1);
    check_eq("good_frame_err", bus.frame_err, 0);
    check_eq("good_overrun", bus.overrun, 0);
    check_eq("good_busy", bus.busy, 0);
    bus.rx_ready = 1'b1;
    tick();
    check_eq("hs_rx_valid", bus.rx_valid, 0);
    bus.rx_ready = 1'b0;
    idle(2, 0);

    // False start
    false_start(1'b1);
    idle(2, 0);

    // Frame error
    send_frame(8'h3C, 1'b0, 0, 1'b0, -1);
    check_eq("fe_pulse", bus.frame_err, 1);
    check_eq("fe_rx_valid", bus.rx_valid, 0);
    check_eq("fe_det_clear", bus.det_clear, 1);
    idle(1, 0);
    check_eq("fe_pulse_end", bus.frame_err, 0);
    idle(1, 0);

    // Overrun: second byte dropped
    send_frame(8'h11, 1'b1, 0, 1'b0, -1);
    idle(2, 0);
    send_frame(8'h22, 1'b1, 0, 1'b0, -1);
    check_eq("ov_pulse", bus.overrun, 1);
    check_eq("ov_rx_data", bus.rx_data, 32'h11);
    check_eq("ov_rx_valid", bus.rx_valid, 1);
    idle(1, 0);
    check_eq("ov_pulse_end", bus.overrun, 0);
    drain();

    // Same pair with a handshake in the stop-sample cycle
    send_frame(8'h11, 1'b1, 0, 1'b0, -1);
    idle(2, 0);
    send_frame(8'h22, 1'b1, 2, 1'b0, -1);
    check_eq("ld_hs_rx_data", bus.rx_data, 32'h22);
    check_eq("ld_hs_rx_valid", bus.rx_valid, 1);
    check_eq("ld_hs_overrun", bus.overrun, 0);
    drain();

    // Extra start pulses mid-frame are ignored
    send_frame(8'h96, 1'b1, 0, 1'b1, -1);
    check_eq("xs_rx_data", bus.rx_data, 32'h96);
    check_eq("xs_rx_valid", bus.rx_valid, 1);
    drain();

    // Reset in DATA at frame cycle 60, then a clean frame
    send_frame(8'h77, 1'b1, 0, 1'b0, 60);
    check_eq("mr_busy", bus.busy, 0);
    check_eq("mr_rx_valid", bus.rx_valid, 0);
    check_eq("mr_rx_data", bus.rx_data, 0);
    check_eq("mr_det_clear", bus.det_clear, 0);
    idle(3, 0);
    send_frame(8'h5A, 1'b1, 0, 1'b0, -1);
    check_eq("after_rst_rx_data", bus.rx_data, 32'h5A);
    check_eq("after_rst_rx_valid", bus.rx_valid, 1);
    drain();

    // Randomized traffic, model-checked every cycle
    for (int n = 0; n < 40; n++) begin
      act = $urandom_range(0, 9);
      if (act < 8) begin
        send_frame(8'($urandom), ($urandom_range(0, 5) != 0), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), -1);
      end else if (act == 8) begin
        false_start(1'b0);
      end else begin
        send_frame(8'($urandom), 1'b1, 1, 1'b0, $urandom_range(5, OUT_T));
      end
      gap = $urandom_range(0, 3);
      idle(gap, 1'b1);
    end
    idle(4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
